flit_packetizer: RTL and testbench



---
 rtl/flit_packetizer_pkg.sv | 32 +++
 rtl/flit_packetizer_if.sv | 52 +++++
 rtl/flit_packetizer_serializer.sv | 68 ++++++
 rtl/flit_packetizer.sv | 163 ++++++++++++++++
 tb/tb_flit_packetizer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/flit_packetizer_pkg.sv
// Shared definitions for the flit packetizer: head-flit field offsets,
// FSM state encoding and the derived-width helper functions.
package flit_packetizer_pkg;

    // Head-flit field layout when the XY coordinate format is used.
    localparam int NIBBLE_W   = 4;
    localparam int DEST_Y_LSB = 0;
    localparam int DEST_X_LSB = 4;
    localparam int SRC_Y_LSB  = 8;
    localparam int SRC_X_LSB  = 12;

    // Raw-index format: source index occupies the upper byte of the low 16 bits.
    localparam int SRC_IDX_LSB = 8;
    localparam int SRC_IDX_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_t;

    // Width of the body-flit length field.
    function automatic int len_w(input int max_body);
        return $clog2(max_body + 1);
    endfunction

    // Width of one flit.
    function automatic int flit_w(input int data_width, input int phit_per_flit);
        return data_width * phit_per_flit;
    endfunction

endpackage

// File: rtl/flit_packetizer_if.sv
// Handshake bundle for the flit packetizer.
//   descriptor : msg_dest, msg_len, msg_valid -> msg_ready
//   body flits : body_data, body_valid       -> body_ready
//   phit out   : phit_out, phit_valid, phit_head, phit_tail <- phit_ready
// slave  : packetizer side
// master : environment side (message source + downstream router)
interface flit_packetizer_if
    import flit_packetizer_pkg::*;
#(
    parameter int N           = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int PhitPerFlit = 2,
    parameter int MAX_BODY    = 15
);
    localparam int DEST_W = $clog2(N);
    localparam int LEN_W  = len_w(MAX_BODY);
    localparam int FLIT_W = flit_w(DATA_WIDTH, PhitPerFlit);

    logic [DEST_W-1:0]     msg_dest;
    logic [LEN_W-1:0]      msg_len;
    logic                  msg_valid;
    logic                  msg_ready;

    logic [FLIT_W-1:0]     body_data;
    logic                  body_valid;
    logic                  body_ready;

    logic [DATA_WIDTH-1:0] phit_out;
    logic                  phit_valid;
    logic                  phit_ready;
    logic                  phit_head;
    logic                  phit_tail;

    modport slave (
        input  msg_dest, msg_len, msg_valid,
        output msg_ready,
        input  body_data, body_valid,
        output body_ready,
        output phit_out, phit_valid, phit_head, phit_tail,
        input  phit_ready
    );

    modport master (
        output msg_dest, msg_len, msg_valid,
        input  msg_ready,
        output body_data, body_valid,
        input  body_ready,
        input  phit_out, phit_valid, phit_head, phit_tail,
        output phit_ready
    );

endinterface

// File: rtl/flit_packetizer_serializer.sv
// flit_serializer: loads one FLIT_W flit and emits it least-significant phit
// first under valid/ready. Head/tail markers are latched with the flit and
// presented on its first/last phit respectively.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   load, flit_in       load a new flit (only when empty or last phit leaving)
//   head_in, tail_in    flit is a head / final flit of the packet
//   phit, valid, ready  phit stream
//   last                current phit is the last of the flit
//   head, tail          phit-level head / tail markers
module flit_serializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int PhitPerFlit = 2,
    parameter int FLIT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [FLIT_W-1:0]     flit_in,
    input  logic                  head_in,
    input  logic                  tail_in,
    output logic [DATA_WIDTH-1:0] phit,
    output logic                  valid,
    input  logic                  ready,
    output logic                  last,
    output logic                  head,
    output logic                  tail
);
    localparam int CNT_W = (PhitPerFlit > 1) ? $clog2(PhitPerFlit) : 1;

    logic [FLIT_W-1:0] sreg;
    logic [CNT_W-1:0]  cnt;
    logic              full;
    logic              head_q;
    logic              tail_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg   <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            head_q <= 1'b0;
            tail_q <= 1'b0;
        end else if (load) begin
            sreg   <= flit_in;
            cnt    <= '0;
            full   <= 1'b1;
            head_q <= head_in;
            tail_q <= tail_in;
        end else if (full && ready) begin
            if (last) begin
                full <= 1'b0;
                cnt  <= '0;
            end else begin
                sreg <= sreg >> DATA_WIDTH;
                cnt  <= cnt + 1'b1;
            end
        end
    end

    assign last  = full && (cnt == CNT_W'(PhitPerFlit - 1));
    assign valid = full;
    // Outputs are forced to zero while empty so the idle bus reads as reset.
    assign phit  = full ? sreg[DATA_WIDTH-1:0] : '0;
    assign head  = full && head_q && (cnt == '0);
    assign tail  = last && tail_q;

endmodule

// File: rtl/flit_packetizer.sv
// flit_packetizer: local-injection transmit block. Accepts a descriptor
// (destination, body-flit count), builds the head flit, then serialises the
// head and body flits into DATA_WIDTH phits with head/tail markers.
// Ports:
//   clk   clock
//   rst   synchronous active-low reset
//   bus   flit_packetizer_if.slave (descriptor, body flits, phit stream)
//
// state | meaning
// IDLE  | waiting for a descriptor, msg_ready high
// HEAD  | head flit phits being sent
// BODY  | body flits being loaded and sent, until tail phit accepted
module flit_packetizer
    import flit_packetizer_pkg::*;
#(
    parameter int N           = 4,
    parameter int DIM         = 2,
    parameter int INDEX       = 1,
    parameter int DATA_WIDTH  = 8,
    parameter int PhitPerFlit = 2,
    parameter int MAX_BODY    = 15,
    parameter int XY_FORMAT   = 1
) (
    input  logic            clk,
    input  logic            rst,
    flit_packetizer_if.slave bus
);
    localparam int DEST_W = $clog2(N);
    localparam int LEN_W  = len_w(MAX_BODY);
    localparam int FLIT_W = flit_w(DATA_WIDTH, PhitPerFlit);

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  body_cnt;
    logic [LEN_W-1:0]  body_cnt_nxt;
    // Low for the first cycle after reset so msg_ready reads 0 during reset.
    logic              out_en;

    logic              msg_ready;
    logic              body_ready;

    logic              ser_load;
    logic [FLIT_W-1:0] ser_flit;
    logic              ser_head_in;
    logic              ser_tail_in;
    logic [DATA_WIDTH-1:0] ser_phit;
    logic              ser_valid;
    logic              ser_last;
    logic              ser_head;
    logic              ser_tail;
    logic              accept_last;

    function automatic logic [FLIT_W-1:0] head_flit(input logic [DEST_W-1:0] dest);
        logic [FLIT_W-1:0] f;
        int                d;
        f = '0;
        d = int'(dest);
        if (XY_FORMAT != 0) begin
            f[DEST_Y_LSB +: NIBBLE_W] = NIBBLE_W'(d / DIM);
            f[DEST_X_LSB +: NIBBLE_W] = NIBBLE_W'(d % DIM);
            f[SRC_Y_LSB  +: NIBBLE_W] = NIBBLE_W'(INDEX / DIM);
            f[SRC_X_LSB  +: NIBBLE_W] = NIBBLE_W'(INDEX % DIM);
        end else begin
            f[DEST_W-1:0]                  = dest;
            f[SRC_IDX_LSB +: SRC_IDX_W]    = SRC_IDX_W'(INDEX);
        end
        return f;
    endfunction

    assign accept_last = ser_last && bus.phit_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            body_cnt <= '0;
            out_en   <= 1'b0;
        end else begin
            state    <= state_nxt;
            body_cnt <= body_cnt_nxt;
            out_en   <= 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        body_cnt_nxt = body_cnt;
        msg_ready    = 1'b0;
        body_ready   = 1'b0;
        ser_load     = 1'b0;
        ser_flit     = bus.body_data;
        ser_head_in  = 1'b0;
        ser_tail_in  = 1'b0;

        case (state)
            IDLE: begin
                msg_ready = out_en;
                if (bus.msg_valid && out_en) begin
                    ser_load     = 1'b1;
                    ser_flit     = head_flit(bus.msg_dest);
                    ser_head_in  = 1'b1;
                    ser_tail_in  = (bus.msg_len == '0);
                    body_cnt_nxt = bus.msg_len;
                    state_nxt    = HEAD;
                end
            end
            HEAD: begin
                if (accept_last) begin
                    if (body_cnt == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        // First body flit may load as the head's last phit
                        // leaves, so head and body run back-to-back.
                        state_nxt  = BODY;
                        body_ready = 1'b1;
                    end
                end
            end
            BODY: begin
                body_ready = (body_cnt != '0) && (!ser_valid || accept_last);
                // body_cnt reaches 0 when the final flit loads, so the flit
                // finishing here with a zero count is the tail flit.
                if (accept_last && body_cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (body_ready && bus.body_valid) begin
            ser_load     = 1'b1;
            ser_flit     = bus.body_data;
            ser_tail_in  = (body_cnt == LEN_W'(1));
            body_cnt_nxt = body_cnt - 1'b1;
        end
    end

    flit_serializer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PhitPerFlit (PhitPerFlit),
        .FLIT_W      (FLIT_W)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (ser_load),
        .flit_in (ser_flit),
        .head_in (ser_head_in),
        .tail_in (ser_tail_in),
        .phit    (ser_phit),
        .valid   (ser_valid),
        .ready   (bus.phit_ready),
        .last    (ser_last),
        .head    (ser_head),
        .tail    (ser_tail)
    );

    assign bus.msg_ready  = msg_ready;
    assign bus.body_ready = body_ready;
    assign bus.phit_out   = ser_phit;
    assign bus.phit_valid = ser_valid;
    assign bus.phit_head  = ser_head;
    assign bus.phit_tail  = ser_tail;

endmodule

// File: tb/tb_flit_packetizer.sv
// Directed bench for flit_packetizer. DUT a uses XY head format, DUT b the
// raw-index format; both share clock, reset and body/phit inputs, and only
// the selected one receives msg_valid.
module tb_flit_packetizer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  msg_dest = '0;
    logic [3:0]  msg_len = '0;
    logic        msg_valid_a = 1'b0;
    logic        msg_valid_b = 1'b0;
    logic [15:0] body_data = '0;
    logic        body_valid = 1'b0;
    logic        phit_ready = 1'b1;
    bit          sel_b = 1'b0;

    always #5 clk = ~clk;

    flit_packetizer_if #(.N(4), .DATA_WIDTH(8), .PhitPerFlit(2), .MAX_BODY(15)) bus_a ();
    flit_packetizer_if #(.N(4), .DATA_WIDTH(8), .PhitPerFlit(2), .MAX_BODY(15)) bus_b ();

    assign bus_a.msg_dest   = msg_dest;
    assign bus_a.msg_len    = msg_len;
    assign bus_a.msg_valid  = msg_valid_a;
    assign bus_a.body_data  = body_data;
    assign bus_a.body_valid = body_valid;
    assign bus_a.phit_ready = phit_ready;
    assign bus_b.msg_dest   = msg_dest;
    assign bus_b.msg_len    = msg_len;
    assign bus_b.msg_valid  = msg_valid_b;
    assign bus_b.body_data  = body_data;
    assign bus_b.body_valid = body_valid;
    assign bus_b.phit_ready = phit_ready;

    flit_packetizer #(.N(4), .DIM(2), .INDEX(1), .DATA_WIDTH(8), .PhitPerFlit(2),
                      .MAX_BODY(15), .XY_FORMAT(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    flit_packetizer #(.N(4), .DIM(2), .INDEX(1), .DATA_WIDTH(8), .PhitPerFlit(2),
                      .MAX_BODY(15), .XY_FORMAT(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    logic       o_v, o_h, o_t, o_mr, o_br;
    logic [7:0] o_d;
    always_comb begin
        if (sel_b) begin
            o_v = bus_b.phit_valid; o_d = bus_b.phit_out; o_h = bus_b.phit_head;
            o_t = bus_b.phit_tail;  o_mr = bus_b.msg_ready; o_br = bus_b.body_ready;
        end else begin
            o_v = bus_a.phit_valid; o_d = bus_a.phit_out; o_h = bus_a.phit_head;
            o_t = bus_a.phit_tail;  o_mr = bus_a.msg_ready; o_br = bus_a.body_ready;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packet run results
    int         np, bi, body_hs, bubbles, ns, mr_busy;
    int         t_msg, t_first, t_last;
    bit         done, aborted;
    logic [7:0] ph_d [8];
    logic       ph_h [8];
    logic       ph_t [8];
    logic [7:0] st_d [8];
    logic       post_mr, post_v;
    logic [7:0] exp_d [8];

    task automatic run_pkt(input bit use_b, input int dest, input int len,
                           input logic [15:0] f0, input logic [15:0] f1,
                           input int stall_phit, input int stall_n,
                           input int gap_flit, input int gap_n, input int abort_phit);
        logic [15:0] fl [2];
        bit taken;
        int stall_left, gap_left;
        fl[0] = f0; fl[1] = f1;
        sel_b = use_b;
        np = 0; bi = 0; body_hs = 0; bubbles = 0; ns = 0; mr_busy = 0;
        t_msg = -1; t_first = -1; t_last = -1;
        done = 0; aborted = 0; taken = 0;
        stall_left = stall_n; gap_left = gap_n;
        msg_dest = 2'(dest);
        msg_len  = 4'(len);
        for (int c = 0; c < 200 && !done && !aborted; c++) begin
            @(negedge clk);
            msg_valid_a = !taken && !use_b;
            msg_valid_b = !taken && use_b;
            body_valid  = (bi < len) && !(bi == gap_flit && gap_left > 0);
            body_data   = fl[bi % 2];
            phit_ready  = !(np == stall_phit && stall_left > 0);
            #1;
            if (np == abort_phit && o_v) begin
                rst = 1'b0;
                aborted = 1;
            end else begin
                if (taken && o_mr) mr_busy++;
                if (!taken && o_mr) begin
                    taken = 1;
                    t_msg = c;
                end
                if (o_v && phit_ready) begin
                    if (np == 0) t_first = c;
                    if (np < 8) begin
                        ph_d[np] = o_d; ph_h[np] = o_h; ph_t[np] = o_t;
                    end
                    np++;
                    if (o_t) begin
                        done = 1;
                        t_last = c;
                    end
                end else if (o_v) begin
                    st_d[ns % 8] = o_d;
                    ns++;
                    stall_left--;
                end else if (np > 0) begin
                    bubbles++;
                end
                if (body_valid && o_br) begin
                    bi++;
                    body_hs++;
                end else if (o_br && bi == gap_flit && gap_left > 0) begin
                    gap_left--;
                end
            end
        end
        msg_valid_a = 1'b0; msg_valid_b = 1'b0; body_valid = 1'b0; phit_ready = 1'b1;
        if (!aborted) begin
            @(negedge clk); #1;
            post_mr = o_mr;
            post_v  = o_v;
        end
    endtask

    task automatic check_pkt(input string name, input int n);
        check({name, " done"}, 32'(done), 1);
        check({name, " count"}, np, n);
        for (int i = 0; i < n && i < 8; i++) begin
            check($sformatf("%s data%0d", name, i), ph_d[i], exp_d[i]);
            check($sformatf("%s head%0d", name, i), ph_h[i], (i == 0) ? 1 : 0);
            check($sformatf("%s tail%0d", name, i), ph_t[i], (i == n - 1) ? 1 : 0);
        end
        check({name, " msg_ready busy"}, mr_busy, 0);
    endtask

    initial begin
        // Reset state, rst held low
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst phit_valid", o_v, 0);
        check("rst phit_out", o_d, 0);
        check("rst phit_head", o_h, 0);
        check("rst phit_tail", o_t, 0);
        check("rst msg_ready", o_mr, 0);
        check("rst body_ready", o_br, 0);
        rst = 1'b1;
        @(negedge clk); #1;
        check("post-rst msg_ready", o_mr, 1);

        // XY head for dest=2 from INDEX=1 on a 2x2 mesh:
        // DestY=2/2=1 [3:0], DestX=2%2=0 [7:4] -> 0x01
        // SrcY=1/2=0 [11:8], SrcX=1%2=1 [15:12] -> 0x10
        run_pkt(0, 2, 0, 16'h0, 16'h0, -1, 0, -1, 0, -1);
        exp_d[0] = 8'h01; exp_d[1] = 8'h10;
        check_pkt("len0", 2);
        check("len0 latency", t_first - t_msg, 1);
        check("len0 span", t_last - t_first, 1);
        check("len0 msg_ready after", post_mr, 1);
        check("len0 valid after", post_v, 0);

        // dest=3 -> DestY=1, DestX=1 -> 0x11; two body flits back-to-back
        run_pkt(0, 3, 2, 16'hAABB, 16'hCCDD, -1, 0, -1, 0, -1);
        exp_d[0] = 8'h11; exp_d[1] = 8'h10; exp_d[2] = 8'hBB;
        exp_d[3] = 8'hAA; exp_d[4] = 8'hDD; exp_d[5] = 8'hCC;
        check_pkt("b2b", 6);
        check("b2b span", t_last - t_first, 5);
        check("b2b bubbles", bubbles, 0);
        check("b2b body handshakes", body_hs, 2);
        check("b2b msg_ready after", post_mr, 1);

        // Same packet, phit_ready low for 3 cycles on the 2nd phit
        run_pkt(0, 3, 2, 16'hAABB, 16'hCCDD, 1, 3, -1, 0, -1);
        check_pkt("stall", 6);
        check("stall span", t_last - t_first, 8);
        check("stall cycles", ns, 3);
        for (int i = 0; i < 3; i++) check($sformatf("stall hold%0d", i), st_d[i], 8'h10);
        check("stall bubbles", bubbles, 0);

        // body_valid withheld for 2 flit-boundary cycles before 2nd body flit
        run_pkt(0, 3, 2, 16'hAABB, 16'hCCDD, -1, 0, 1, 2, -1);
        check_pkt("gap", 6);
        check("gap bubbles", bubbles, 2);
        check("gap span", t_last - t_first, 7);
        check("gap body handshakes", body_hs, 2);

        // Raw-index head: dest=3 in [1:0], INDEX=1 in [15:8]
        run_pkt(1, 3, 1, 16'h1234, 16'h0, -1, 0, -1, 0, -1);
        exp_d[0] = 8'h03; exp_d[1] = 8'h01; exp_d[2] = 8'h34; exp_d[3] = 8'h12;
        check_pkt("rawidx", 4);
        check("rawidx span", t_last - t_first, 3);
        check("rawidx msg_ready after", post_mr, 1);

        // Reset while the first body phit is on the bus
        run_pkt(0, 3, 2, 16'hAABB, 16'hCCDD, -1, 0, -1, 0, 2);
        check("abort reached", 32'(aborted), 1);
        @(negedge clk); #1;
        check("abort phit_valid", o_v, 0);
        check("abort phit_out", o_d, 0);
        check("abort phit_head", o_h, 0);
        check("abort phit_tail", o_t, 0);
        check("abort msg_ready", o_mr, 0);
        check("abort body_ready", o_br, 0);
        rst = 1'b1;
        @(negedge clk); #1;
        check("abort msg_ready after rst", o_mr, 1);
        run_pkt(0, 2, 1, 16'h5A6B, 16'h0, -1, 0, -1, 0, -1);
        exp_d[0] = 8'h01; exp_d[1] = 8'h10; exp_d[2] = 8'h6B; exp_d[3] = 8'h5A;
        check_pkt("fresh", 4);
        check("fresh span", t_last - t_first, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
